// File: rtl/instr_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_if
//
// Handshake bundle between the fetch stage, the instruction fetch queue and
// the decode stage.
//
//   in_valid    fetch -> queue   fetch offers an entry this cycle
//   in_ready    queue -> fetch   queue accepts an entry this cycle
//   in_instr    fetch -> queue   instruction word from the instruction ROM
//   in_pcplus4  fetch -> queue   PC+4 of that instruction
//   out_valid   queue -> decode  head entry present
//   out_ready   decode -> queue  decode consumes the head entry this cycle
//   out_instr   queue -> decode  head instruction word (0 when empty)
//   out_pcplus8 queue -> decode  head PC+4 plus 4 (0 when empty)
//
// Modports:
//   master  the fetch/decode environment around the queue
//   slave   the queue itself
// -----------------------------------------------------------------------------
interface instr_fetch_queue_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [DATA_WIDTH-1:0] in_pcplus4;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pcplus8;

  modport master (
    output in_valid,
    input  in_ready,
    output in_instr,
    output in_pcplus4,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pcplus8
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_instr,
    input  in_pcplus4,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pcplus8
  );

endinterface : instr_fetch_queue_if

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Circular-buffer queue of fetched instructions between the fetch stage and
// the decode stage. Each entry holds {instr, pcplus4}. Decode pulls entries
// through a valid/ready handshake and receives PC+8 (head PC+4 plus 4) for
// R15 reads. A taken branch (flush) discards every buffered entry.
//
// Parameters:
//   DATA_WIDTH  width of instruction word and PC values
//   DEPTH       number of entries; must be a power of 2 and >= 2
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (asserted at 0)
//   flush  synchronous flush from PCSrc; highest-priority synchronous event
//   bus    handshake bundle (slave side), see instr_fetch_queue_if
//   count  number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  instr_fetch_queue_if.slave      bus,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pcplus4;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  logic            not_empty;
  logic            not_full;
  logic            push;
  logic            pop;
  entry_t          head;

  // Handshake flags depend only on the count register, so there is no
  // combinational path from in_valid to in_ready or from out_ready to
  // out_valid. A full queue therefore refuses a push even while popping.
  assign not_empty = (count_q != '0);
  assign not_full  = (count_q < FULL_COUNT);

  // Flush cancels any transfer offered in the same cycle.
  assign push = bus.in_valid  && not_full  && !flush;
  assign pop  = bus.out_ready && not_empty && !flush;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array deliberately has no reset; the count gates every
  // read, so stale contents are never observed and the array can map onto
  // plain flops or a RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{instr: bus.in_instr, pcplus4: bus.in_pcplus4};
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  // NOTE: every combinational block assigns its outputs a default first so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;   // idle, or push and pop cancel out
    endcase
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so the natural
  // binary rollover implements the DEPTH-1 -> 0 wrap.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head = mem[rd_ptr];

  assign count         = count_q;
  assign bus.in_ready  = not_full;
  assign bus.out_valid = not_empty;

  // Head data is forced to zero while empty. The PC+8 sum is truncated to
  // DATA_WIDTH, so a stored PC+4 of all-ones-minus-3 wraps to zero.
  assign bus.out_instr   = not_empty ? head.instr             : '0;
  assign bus.out_pcplus8 = not_empty ? head.pcplus4 + PC_STEP : '0;

endmodule : instr_fetch_queue

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Scoreboard bench for instr_fetch_queue. A reference model tracks the
// occupancy and pushes every accepted entry's expected {instr, pc+8} into a
// queue at the clock edge; an independent monitor compares the DUT outputs on
// the falling edge and retires the head entry whenever decode consumes it.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc8;
  } exp_t;

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;

  instr_fetch_queue_if #(.DATA_WIDTH(DW)) bus ();

  instr_fetch_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of expected responses plus an occupancy count.
  // ---------------------------------------------------------------------------
  exp_t exp_q[$];
  int   model_count = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      model_count = 0;
    end else if (flush) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      // Acceptance is decided on the pre-edge occupancy.
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && (model_count < DEPTH);
      do_pop  = bus.out_ready && (model_count > 0);
      if (do_push) begin
        exp_t e;
        e.instr = bus.in_instr;
        e.pc8   = bus.in_pcplus4 + 32'd4;
        exp_q.push_back(e);
      end
      model_count = model_count + int'(do_push) - int'(do_pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare on the falling edge, retire the head on a consume.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    check("count",    DW'(count),         DW'(model_count));
    check("out_valid", DW'(bus.out_valid), DW'(model_count != 0));
    check("in_ready", DW'(bus.in_ready),  DW'(model_count < DEPTH));
    if (model_count != 0 && exp_q.size() != 0) begin
      check("out_instr",   bus.out_instr,   exp_q[0].instr);
      check("out_pcplus8", bus.out_pcplus8, exp_q[0].pc8);
      if (reset && !flush && bus.out_ready) void'(exp_q.pop_front());
    end else begin
      check("out_instr_empty",   bus.out_instr,   '0);
      check("out_pcplus8_empty", bus.out_pcplus8, '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [DW-1:0] instr,
                       input logic [DW-1:0] pc4, input logic ordy,
                       input logic fl);
    bus.in_valid   = v;
    bus.in_instr   = instr;
    bus.in_pcplus4 = pc4;
    bus.out_ready  = ordy;
    flush          = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base_instr,
                        input logic [DW-1:0] base_pc4);
    for (int i = 0; i < n; i++)
      drive(1'b1, base_instr + DW'(i), base_pc4 + DW'(4 * i), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_pcplus4 = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",    DW'(count),         32'd0);
    check("rst_in_ready", DW'(bus.in_ready),  32'd1);
    check("rst_out_valid", DW'(bus.out_valid), 32'd0);
    reset = 1'b1;

    // Fill to full, then offer a fifth entry that must be refused.
    push_n(4, 32'hE3A0_0001, 32'h0000_0004);
    check("full_count",    DW'(count),        32'd4);
    check("full_in_ready", DW'(bus.in_ready), 32'd0);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 1'b0);
    check("full_ignore_push", DW'(count), 32'd4);

    // Full with pop: one pop, no push.
    check("full_pop_pc8", bus.out_pcplus8, 32'h0000_0008);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 1'b0);
    check("full_pop_count",    DW'(count),        32'd3);
    check("full_pop_in_ready", DW'(bus.in_ready), 32'd1);
    drain();
    check("drained_valid", DW'(bus.out_valid), 32'd0);

    // Simultaneous push and pop at count 2; pointers wrap several times.
    push_n(2, 32'h1000_0000, 32'h0000_2000);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h2000_0000 + DW'(i), 32'h0000_3000 + DW'(4 * i), 1'b1, 1'b0);
      check("steady_count", DW'(count), 32'd2);
    end
    drain();

    // Flush with count 3 while both a push and a pop are offered.
    push_n(3, 32'h3000_0000, 32'h0000_4000);
    drive(1'b1, 32'hBAD0_0000, 32'h0000_5000, 1'b1, 1'b1);
    check("flush_count", DW'(count),         32'd0);
    check("flush_valid", DW'(bus.out_valid), 32'd0);
    drive(1'b1, 32'hEA00_0005, 32'h0000_0200, 1'b0, 1'b0);
    check("post_flush_valid", DW'(bus.out_valid), 32'd1);
    check("post_flush_instr", bus.out_instr,      32'hEA00_0005);
    drain();

    // PC+8 wraps modulo 2^DW.
    drive(1'b1, 32'hE1A0_0000, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap_pc8", bus.out_pcplus8, 32'h0000_0000);
    drain();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    drain();

    // Asynchronous reset mid-stream with count 3.
    push_n(3, 32'h4000_0000, 32'h0000_6000);
    check("pre_reset_count", DW'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_count",    DW'(count),         32'd0);
    check("async_rst_valid",    DW'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", DW'(bus.in_ready),  32'd1);
    check("async_rst_instr",    bus.out_instr,      32'd0);
    check("async_rst_pc8",      bus.out_pcplus8,    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_n(1, 32'h5000_0000, 32'h0000_7000);
    check("post_rst_push", DW'(count), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch_queue
